// File: rtl/usb_crc_pkg.sv
// USB CRC engine shared types, polynomials and residual constants.
// Helper functions: register init, CRC width, residual match, field packing.
package usb_crc_pkg;

  typedef enum logic {
    CRC5  = 1'b0,
    CRC16 = 1'b1
  } crc_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam int CRC5_W  = 5;
  localparam int CRC16_W = 16;

  localparam logic [4:0]  POLY5  = 5'h05;
  localparam logic [15:0] POLY16 = 16'h8005;
  localparam logic [4:0]  RES5   = 5'b01100;
  localparam logic [15:0] RES16  = 16'h800D;

  function automatic int crc_w(crc_mode_t m);
    return (m == CRC16) ? CRC16_W : CRC5_W;
  endfunction

  function automatic logic [15:0] crc_init(crc_mode_t m);
    return (m == CRC16) ? 16'hFFFF : 16'h001F;
  endfunction

  function automatic logic res_ok(
    crc_mode_t   m,
    logic [15:0] r
  );
    if (m == CRC16) return r == RES16;
    return r[4:0] == RES5;
  endfunction

  // Field bit i is the inverted register MSB-first,
  // so bit 0 of the result goes on the wire first.
  function automatic logic [15:0] crc_field(
    crc_mode_t   m,
    logic [15:0] r
  );
    logic [15:0] f;
    f = '0;
    if (m == CRC16) begin
      for (int i = 0; i < 16; i++)
        f[i] = ~r[15-i];
    end else begin
      for (int i = 0; i < 5; i++)
        f[i] = ~r[4-i];
    end
    return f;
  endfunction

endpackage

// File: rtl/usb_crc_engine_if.sv
// Stream bundle between the packet layer and the USB CRC engine.
// master drives packet beats and out_ready; slave returns CRC beats/status.
interface usb_crc_engine_if #(
  parameter int DATA_W = 8,
  parameter int NB_W   = $clog2(DATA_W) + 1
);

  logic              mode;
  logic              gen_en;
  logic              in_valid;
  logic              in_ready;
  logic              in_sop;
  logic              in_eop;
  logic [DATA_W-1:0] in_data;
  logic [NB_W-1:0]   in_nbits;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NB_W-1:0]   out_nbits;
  logic              out_last;
  logic              chk_done;
  logic              chk_ok;
  logic              sop_err;
  logic [15:0]       crc_value;

  modport master (
    output mode, gen_en,
    output in_valid, in_sop, in_eop,
    output in_data, in_nbits,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data,
    input  out_nbits, out_last,
    input  chk_done, chk_ok,
    input  sop_err, crc_value
  );

  modport slave (
    input  mode, gen_en,
    input  in_valid, in_sop, in_eop,
    input  in_data, in_nbits,
    input  out_ready,
    output in_ready,
    output out_valid, out_data,
    output out_nbits, out_last,
    output chk_done, chk_ok,
    output sop_err, crc_value
  );

endinterface

// File: rtl/usb_crc_step.sv
// One-beat CRC5/CRC16 LFSR update, LSB of data first.
// Ports: r (current), data, nbits (0 = DATA_W), mode -> r_nxt.
module usb_crc_step
  import usb_crc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NB_W   = $clog2(DATA_W) + 1
) (
  input  logic [15:0]       r,
  input  logic [DATA_W-1:0] data,
  input  logic [NB_W-1:0]   nbits,
  input  crc_mode_t         mode,
  output logic [15:0]       r_nxt
);

  int   n;
  logic fb;

  always_comb begin
    n     = (nbits == '0) ? DATA_W : int'(nbits);
    r_nxt = r;
    fb    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < n) begin
        if (mode == CRC16) begin
          fb    = data[i] ^ r_nxt[15];
          r_nxt = {r_nxt[14:0], 1'b0}
                ^ (fb ? POLY16 : 16'h0);
        end else begin
          fb         = data[i] ^ r_nxt[4];
          r_nxt[4:0] = {r_nxt[3:0], 1'b0}
                     ^ (fb ? POLY5 : 5'h0);
        end
      end
    end
  end

endmodule

// File: rtl/usb_crc_engine.sv
// USB CRC5/CRC16 engine: checks residual or appends the CRC field.
// Ports: clk, n_rst (async, active-low), bus (usb_crc_engine_if.slave).
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NB_W   = $clog2(DATA_W) + 1
) (
  input logic             clk,
  input logic             n_rst,
  usb_crc_engine_if.slave bus
);

  localparam int IDX_W = 5;

  state_t            state;
  state_t            state_n;
  logic [15:0]       r;
  logic [15:0]       r_n;
  logic [15:0]       r_base;
  logic [15:0]       r_step;
  crc_mode_t         mode_q;
  crc_mode_t         mode_e;
  logic              gen_q;
  logic              gen_e;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic              chk_done_q;
  logic              chk_done_n;
  logic              chk_ok_q;
  logic              chk_ok_n;
  logic              sop_err_q;
  logic              sop_err_n;
  logic              acc;
  logic              start;
  logic              live;
  logic              fin;
  logic              last;
  logic [NB_W-1:0]   step_nb;
  logic [31:0]       sh;
  int                w;
  int                nbeats;

  assign bus.in_ready = (state != EMIT);

  assign acc   = bus.in_valid & bus.in_ready;
  assign start = acc & bus.in_sop;
  assign live  = start | (acc & (state == ACCUM));
  assign fin   = live & bus.in_eop;

  // sop beat uses its own mode/gen_en before they are latched
  assign mode_e = start ? crc_mode_t'(bus.mode) : mode_q;
  assign gen_e  = start ? bus.gen_en : gen_q;
  assign r_base = start ? crc_init(mode_e) : r;

  assign step_nb = bus.in_eop ? bus.in_nbits : '0;

  usb_crc_step #(
    .DATA_W (DATA_W),
    .NB_W   (NB_W)
  ) u_step (
    .r     (r_base),
    .data  (bus.in_data),
    .nbits (step_nb),
    .mode  (mode_e),
    .r_nxt (r_step)
  );

  always_comb begin
    w      = crc_w(mode_q);
    nbeats = (w + DATA_W - 1) / DATA_W;
    last   = (int'(idx) == nbeats - 1);
    sh     = {16'h0, crc_field(mode_q, r)}
           >> (int'(idx) * DATA_W);
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_nbits = '0;
    bus.out_last  = 1'b0;
    if (state == EMIT) begin
      bus.out_valid = 1'b1;
      bus.out_data  = sh[DATA_W-1:0];
      bus.out_last  = last;
      if (last)
        bus.out_nbits = NB_W'(w % DATA_W);
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    r_n        = r;
    chk_done_n = 1'b0;
    chk_ok_n   = chk_ok_q;
    sop_err_n  = 1'b0;
    if (live)
      r_n = r_step;
    unique case (state)
      IDLE, ACCUM: begin
        sop_err_n = start & (state == ACCUM);
        if (fin) begin
          if (gen_e) begin
            state_n = EMIT;
            idx_n   = '0;
          end else begin
            state_n    = IDLE;
            chk_done_n = 1'b1;
            chk_ok_n   = res_ok(mode_e, r_step);
          end
        end else if (live) begin
          state_n = ACCUM;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last) state_n = IDLE;
          else      idx_n   = idx + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      r          <= 16'hFFFF;
      mode_q     <= CRC16;
      gen_q      <= 1'b0;
      idx        <= '0;
      chk_done_q <= 1'b0;
      chk_ok_q   <= 1'b0;
      sop_err_q  <= 1'b0;
    end else begin
      state      <= state_n;
      r          <= r_n;
      idx        <= idx_n;
      chk_done_q <= chk_done_n;
      chk_ok_q   <= chk_ok_n;
      sop_err_q  <= sop_err_n;
      if (start) begin
        mode_q <= mode_e;
        gen_q  <= gen_e;
      end
    end
  end

  assign bus.chk_done  = chk_done_q;
  assign bus.chk_ok    = chk_ok_q;
  assign bus.sop_err   = sop_err_q;
  assign bus.crc_value = r;

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine at DATA_W=8.
// Vector table for packets plus stall, restart and reset sequences.
module tb_usb_crc_engine;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  usb_crc_engine_if #(.DATA_W(8)) bus ();

  usb_crc_engine #(.DATA_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         mode;
    logic         gen;
    int           n;
    logic [95:0]  bytes;
    logic [3:0]   lnb;
    logic         exp_ok;
    logic [15:0]  exp_crc;
    int           beats;
    logic [7:0]   d0;
    logic [7:0]   d1;
    logic [3:0]   nb_last;
  } vec_t;

  vec_t vt [6];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic send(
    input logic       sop,
    input logic       eop,
    input logic [7:0] d,
    input logic [3:0] nb
  );
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
    bus.in_data  = d;
    bus.in_nbits = nb;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v);
    bus.mode   = v.mode;
    bus.gen_en = v.gen;
    for (int k = 0; k < v.n; k++)
      send(k == 0, k == v.n - 1,
           v.bytes[k*8 +: 8],
           (k == v.n - 1) ? v.lnb : 4'd0);
  endtask

  task automatic wait_out(input string nm);
    int t;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic collect(input vec_t v);
    logic [7:0] ed;
    for (int b = 0; b < v.beats; b++) begin
      wait_out(v.name);
      ed = (b == 0) ? v.d0 : v.d1;
      chk({v.name, "_data"}, 32'(bus.out_data), 32'(ed));
      chk({v.name, "_last"}, 32'(bus.out_last),
          32'(b == v.beats - 1));
      chk({v.name, "_nbits"}, 32'(bus.out_nbits),
          (b == v.beats - 1) ? 32'(v.nb_last) : 32'd0);
      @(posedge clk);
      #1;
    end
    chk({v.name, "_ready_after"},
        32'(bus.in_ready), 32'd1);
    chk({v.name, "_valid_after"},
        32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    send_pkt(v);
    if (v.gen) begin
      chk({v.name, "_in_ready_emit"},
          32'(bus.in_ready), 32'd0);
      chk({v.name, "_valid_lat"},
          32'(bus.out_valid), 32'd1);
      collect(v);
    end else begin
      chk({v.name, "_chk_done"},
          32'(bus.chk_done), 32'd1);
      chk({v.name, "_chk_ok"},
          32'(bus.chk_ok), 32'(v.exp_ok));
      if (v.exp_ok)
        chk({v.name, "_residual"},
            32'(bus.crc_value), 32'(v.exp_crc));
      @(posedge clk);
      #1;
      chk({v.name, "_done_pulse"},
          32'(bus.chk_done), 32'd0);
      chk({v.name, "_ok_hold"},
          32'(bus.chk_ok), 32'(v.exp_ok));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] held;
    logic [71:0] msg;
    checks    = 0;
    failures  = 0;
    msg       = 72'h39_38_37_36_35_34_33_32_31;

    vt[0] = '{"c16_gen", 1'b1, 1'b1, 9,
              {24'h0, msg}, 4'd0, 1'b0, 16'h0,
              2, 8'hC8, 8'hB4, 4'd0};
    vt[1] = '{"c16_chk", 1'b1, 1'b0, 11,
              {8'h0, 16'hB4C8, msg}, 4'd0,
              1'b1, 16'h800D, 0, 8'h0, 8'h0, 4'd0};
    vt[2] = '{"c16_bad", 1'b1, 1'b0, 11,
              {8'h0, 16'hB4C8,
               msg ^ 72'h01_000000}, 4'd0,
              1'b0, 16'h0, 0, 8'h0, 8'h0, 4'd0};
    vt[3] = '{"c5_gen", 1'b0, 1'b1, 9,
              {24'h0, msg}, 4'd0, 1'b0, 16'h0,
              1, 8'h19, 8'h00, 4'd5};
    vt[4] = '{"c5_chk", 1'b0, 1'b0, 10,
              {16'h0, 8'h19, msg}, 4'd5,
              1'b1, 16'h000C, 0, 8'h0, 8'h0, 4'd0};
    vt[5] = '{"c5_bad", 1'b0, 1'b0, 10,
              {16'h0, 8'h18, msg}, 4'd5,
              1'b0, 16'h0, 0, 8'h0, 8'h0, 4'd0};

    n_rst         = 1'b0;
    bus.mode      = 1'b0;
    bus.gen_en    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.in_data   = '0;
    bus.in_nbits  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_nbits", 32'(bus.out_nbits), 32'd0);
    chk("rst_chk_done", 32'(bus.chk_done), 32'd0);
    chk("rst_chk_ok", 32'(bus.chk_ok), 32'd0);
    chk("rst_sop_err", 32'(bus.sop_err), 32'd0);
    chk("rst_crc", 32'(bus.crc_value), 32'h0000FFFF);

    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      run_vec(vt[i]);

    // beat without sop while idle is dropped
    held = bus.crc_value;
    send(1'b0, 1'b0, 8'hA5, 4'd0);
    chk("drop_crc", 32'(bus.crc_value), 32'(held));
    chk("drop_done", 32'(bus.chk_done), 32'd0);

    // stall the CRC output for three cycles
    bus.out_ready = 1'b0;
    send_pkt(vt[0]);
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'hC8);
      chk("stall_last", 32'(bus.out_last), 32'd0);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    collect(vt[0]);

    // sop mid-packet restarts the packet
    bus.mode   = 1'b1;
    bus.gen_en = 1'b0;
    for (int k = 0; k < 4; k++)
      send(k == 0, 1'b0, msg[k*8 +: 8], 4'd0);
    chk("restart_no_err", 32'(bus.sop_err), 32'd0);
    send(1'b1, 1'b0, vt[1].bytes[7:0], 4'd0);
    chk("restart_sop_err", 32'(bus.sop_err), 32'd1);
    for (int k = 1; k < 11; k++) begin
      send(1'b0, k == 10, vt[1].bytes[k*8 +: 8], 4'd0);
      if (k == 1)
        chk("restart_err_pulse",
            32'(bus.sop_err), 32'd0);
    end
    chk("restart_done", 32'(bus.chk_done), 32'd1);
    chk("restart_ok", 32'(bus.chk_ok), 32'd1);
    @(posedge clk);
    #1;

    // reset while emitting aborts the packet
    bus.out_ready = 1'b0;
    send_pkt(vt[0]);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_crc", 32'(bus.crc_value), 32'h0000FFFF);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_done", 32'(bus.chk_done), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_done", 32'(bus.chk_done), 32'd0);
    run_vec(vt[1]);
    run_vec(vt[3]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_crc_engine.md
Name: usb_crc_engine

Overview:
Parametrised, run-time selectable USB CRC engine supporting CRC5 (token) and CRC16 (data) on a framed, beat-wide input stream.
- Check mode: flags packet validity from the residual after the whole packet, CRC field included, has been accepted.
- Generate mode: after end-of-packet, emits the inverted CRC field as output beats under valid/ready handshake.
- Sits between the USB packet decoder/encoder and the bit-stuffing layer; shared by the RX and TX packet paths.

Parameters:
DATA_W, 8, bits per input/output beat (1..16); bits are consumed LSB first.
NB_W, $clog2(DATA_W)+1, width of the valid-bit-count fields.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
mode  in  1  0=CRC5, 1=CRC16; sampled on the accepted sop beat
gen_en  in  1  1=generate/append, 0=check; sampled on the accepted sop beat
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept a beat
in_sop  in  1  first beat of packet
in_eop  in  1  last beat of packet
in_data  in  DATA_W  packet bits, LSB first
in_nbits  in  NB_W  valid bits in the eop beat (0 means DATA_W); ignored on non-eop beats
out_valid  out  1  CRC beat valid
out_ready  in  1  downstream accepts CRC beat
out_data  out  DATA_W  CRC field bits, LSB transmitted first
out_nbits  out  NB_W  valid bits in out_data (0 means DATA_W)
out_last  out  1  final CRC beat
chk_done  out  1  one-cycle pulse: check result valid
chk_ok  out  1  residual matched; valid while chk_done=1, otherwise holds the last result
sop_err  out  1  one-cycle pulse: sop received mid-packet
crc_value  out  16  raw LFSR register

Behaviour:
- LFSR: 16-bit register r; W=5 (CRC5) or 16 (CRC16).
- Per data bit d: fb = d ^ r[W-1]; r[W-1:0] = {r[W-2:0],0} ^ (fb ? POLY : 0).
- POLY: CRC5 5'h05, CRC16 16'h8005.
- Initialisation on an accepted sop beat: r[W-1:0] set to all ones, upper bits 0, before that beat is processed.
- RESIDUAL: CRC5 5'b01100, CRC16 16'h800D.
- One beat per cycle, full rate. An eop beat processes only in_nbits bits.
- CRC field bit i (i=0 first) = ~r[W-1-i]; packed LSB first into ceil(W/DATA_W) beats; the final beat carries out_nbits = W mod DATA_W (0 means full).
- Handshake: a beat is accepted when in_valid & in_ready, and emitted when out_valid & out_ready. out_data and out_valid are held stable while out_ready=0.
- FSM states:
  IDLE: in_ready=1. An accepted beat without sop is dropped silently. sop accepted -> ACCUM, or handle as eop if in_eop is also set.
  ACCUM: in_ready=1; beats accumulate. Accepted eop: gen_en=1 -> EMIT; gen_en=0 -> IDLE, with chk_done=1 and chk_ok=(r[W-1:0]==RESIDUAL) registered in the following cycle. Accepted sop: sop_err pulse, register re-initialised, packet restarts.
  EMIT: in_ready=0, out_valid=1, beat index advances on each handshake; out_last on the final beat; last handshake -> IDLE.
- Latency: chk_done one cycle after the eop handshake. out_valid rises one cycle after the eop handshake.
- Reset values: state IDLE, r=16'hFFFF (crc_value=16'hFFFF), in_ready=1, out_valid=0, out_last=0, out_data=0, out_nbits=0, chk_done=0, chk_ok=0, sop_err=0. Reset during any state aborts the packet with no pulses.
- The register is not advanced in EMIT. crc_value is frozen after check until the next sop.

Decomposition:
- Package usb_crc_pkg: crc_mode_t enum (CRC5, CRC16), state_t enum (IDLE, ACCUM, EMIT), POLY5, POLY16, RES5, RES16, CRC5_W, CRC16_W constants.
- Sub-module usb_crc_step (combinational): inputs r, data, nbits, mode; output next r. Implemented as a bit loop; instantiated once.

Test Plan:
1. mode=1, gen_en=1, DATA_W=8, bytes 0x31..0x39 ("123456789") with sop/eop -> out beats 0xC8 then 0xB4, out_last on the second, out_nbits=0.
2. mode=1, gen_en=0, same 9 bytes + 0xC8, 0xB4 -> chk_done with chk_ok=1 one cycle after eop; flip bit 0 of byte 3 -> chk_ok=0.
3. mode=0, gen_en=1, same 9 bytes -> one beat, out_data[4:0]=5'h19, out_nbits=5; check-mode replay with a final beat 0x19, in_nbits=5 -> chk_ok=1.
4. Hold out_ready=0 for 3 cycles in EMIT -> out_data/out_valid stable, in_ready=0; out_ready=1 -> beats complete, then in_ready=1.
5. sop mid-packet after 4 bytes, then the 9-byte check packet -> sop_err pulse, final chk_ok=1.
6. n_rst low during EMIT -> out_valid=0, crc_value=16'hFFFF, in_ready=1, no chk_done; next packet processes normally.
